// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, control encodings, the ID/EX
// pipeline record and the combinational control / immediate decoders.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int RIDX = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLT  = 4'h5,
        ALU_SLTU = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9,
        ALU_LUI  = 4'hA
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_e;

    typedef struct packed {
        logic        reg_write;
        imm_src_e    imm_src;
        logic        alu_src;
        logic        mem_write;
        result_src_e result_src;
        logic        branch;
        logic        jump;
        alu_ctrl_e   alu_control;
    } ctrl_t;

    // Register indices are kept at the full instruction-field width; the
    // block truncates them to its own register-file index width.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [RIDX-1:0] rs1;
        logic [RIDX-1:0] rs2;
        logic [RIDX-1:0] rd;
        result_src_e     result_src;
        logic            mem_write;
        logic            alu_src;
        logic            reg_write;
        logic            branch;
        logic            jump;
        alu_ctrl_e       alu_control;
        logic [2:0]      funct3;
    } id_ex_t;

    // All-zero record doubles as the reset value of ID/EX.
    localparam id_ex_t ID_EX_BUBBLE = '0;

    function automatic alu_ctrl_e alu_decode(input logic [2:0] f3, input logic f7b5,
                                             input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Main control decoder; unknown opcodes decode to a harmless no-op.
    function automatic ctrl_t control_decode(input logic [XLEN-1:0] instr);
        ctrl_t c;
        c = '0;
        case (instr[6:0])
            OP_LOAD: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.result_src = RES_MEM;
            end
            OP_STORE: begin
                c.imm_src   = IMM_S;
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_RTYPE: begin
                c.reg_write   = 1'b1;
                c.alu_control = alu_decode(instr[14:12], instr[30], 1'b1);
            end
            OP_ITYPE: begin
                c.reg_write   = 1'b1;
                c.alu_src     = 1'b1;
                c.alu_control = alu_decode(instr[14:12], instr[30], 1'b0);
            end
            OP_BRANCH: begin
                c.imm_src     = IMM_B;
                c.branch      = 1'b1;
                c.alu_control = ALU_SUB;
            end
            OP_JAL: begin
                c.reg_write  = 1'b1;
                c.imm_src    = IMM_J;
                c.result_src = RES_PC4;
                c.jump       = 1'b1;
            end
            OP_JALR: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.result_src = RES_PC4;
                c.jump       = 1'b1;
            end
            OP_LUI: begin
                c.reg_write   = 1'b1;
                c.imm_src     = IMM_U;
                c.alu_src     = 1'b1;
                c.alu_control = ALU_LUI;
            end
            OP_AUIPC: begin
                c.reg_write = 1'b1;
                c.imm_src   = IMM_U;
                c.alu_src   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [XLEN-1:0] sign_extend(input logic [XLEN-1:0] i,
                                                    input imm_src_e src);
        case (src)
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: return {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/decode_pipe_if.sv
// IF/ID, write-back, flush and ID/EX signal bundle around the decode stage.
interface decode_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  if_valid;
    logic [DATA_WIDTH-1:0] if_instr;
    logic [DATA_WIDTH-1:0] if_pc;
    logic                  wb_we;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  ex_flush;
    logic                  stall;
    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_pc;
    logic [DATA_WIDTH-1:0] ex_rd1;
    logic [DATA_WIDTH-1:0] ex_rd2;
    logic [DATA_WIDTH-1:0] ex_imm;
    logic [ADDR_WIDTH-1:0] ex_rs1;
    logic [ADDR_WIDTH-1:0] ex_rs2;
    logic [ADDR_WIDTH-1:0] ex_rd;
    logic [1:0]            ex_result_src;
    logic                  ex_mem_write;
    logic                  ex_alu_src;
    logic                  ex_reg_write;
    logic                  ex_branch;
    logic                  ex_jump;
    logic [3:0]            ex_alu_control;
    logic [2:0]            ex_funct3;

    // Decode stage side.
    modport slave (
        input  if_valid, if_instr, if_pc, wb_we, wb_rd, wb_data, ex_flush,
        output stall, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_result_src, ex_mem_write, ex_alu_src, ex_reg_write, ex_branch,
               ex_jump, ex_alu_control, ex_funct3
    );

    // Surrounding pipeline side.
    modport master (
        output if_valid, if_instr, if_pc, wb_we, wb_rd, wb_data, ex_flush,
        input  stall, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_result_src, ex_mem_write, ex_alu_src, ex_reg_write, ex_branch,
               ex_jump, ex_alu_control, ex_funct3
    );
endinterface

// File: rtl/decode_pipe_hazard_unit.sv
// Load-use detection against the instruction in ID/EX, with flush priority.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_ex_valid,
    input  logic [1:0]            i_ex_result_src,
    input  logic [ADDR_WIDTH-1:0] i_ex_rd,
    input  logic                  i_if_valid,
    input  logic [ADDR_WIDTH-1:0] i_rs1,
    input  logic [ADDR_WIDTH-1:0] i_rs2,
    input  logic                  i_ex_flush,
    output logic                  o_stall,
    output logic                  o_bubble
);
    logic w_load_use;

    // rs2 is compared even for formats without an rs2 field; the rare extra stall is harmless.
    always_comb begin
        w_load_use = i_ex_valid && (i_ex_result_src == RES_MEM) && (i_ex_rd != '0) &&
                     i_if_valid && ((i_ex_rd == i_rs1) || (i_ex_rd == i_rs2));
        o_stall    = w_load_use && !i_ex_flush;
        o_bubble   = i_ex_flush || w_load_use || !i_if_valid;
    end
endmodule

// File: rtl/decode_pipe.sv
// RV32I decode stage: control/immediate decode, register file with write-through
// bypass, load-use stall and the ID/EX pipeline register.
module decode_pipe
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_pipe_if.slave          bus,
    output logic [DATA_WIDTH-1:0] a0
);
    logic [DATA_WIDTH-1:0] r_rf [2**ADDR_WIDTH];
    id_ex_t                r_idex;

    logic [XLEN-1:0]       w_instr;
    logic [ADDR_WIDTH-1:0] w_rs1;
    logic [ADDR_WIDTH-1:0] w_rs2;
    logic [ADDR_WIDTH-1:0] w_ex_rd;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;
    logic                  w_wb_en;
    ctrl_t                 w_ctrl;
    id_ex_t                w_next;
    logic                  w_stall;
    logic                  w_bubble;

    assign w_instr = XLEN'(bus.if_instr);
    assign w_rs1   = ADDR_WIDTH'(w_instr[19:15]);
    assign w_rs2   = ADDR_WIDTH'(w_instr[24:20]);
    assign w_ex_rd = ADDR_WIDTH'(r_idex.rd);
    assign w_wb_en = bus.wb_we && (bus.wb_rd != '0);
    assign w_ctrl  = control_decode(w_instr);

    // Write-through: a same-cycle write-back to the source register wins over the array.
    assign w_rd1 = (w_rs1 == '0) ? '0 :
                   (w_wb_en && bus.wb_rd == w_rs1) ? bus.wb_data : r_rf[w_rs1];
    assign w_rd2 = (w_rs2 == '0) ? '0 :
                   (w_wb_en && bus.wb_rd == w_rs2) ? bus.wb_data : r_rf[w_rs2];
    assign a0    = r_rf[ADDR_WIDTH'(10)];

    hazard_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_hazard (
        .i_ex_valid      (r_idex.valid),
        .i_ex_result_src (r_idex.result_src),
        .i_ex_rd         (w_ex_rd),
        .i_if_valid      (bus.if_valid),
        .i_rs1           (w_rs1),
        .i_rs2           (w_rs2),
        .i_ex_flush      (bus.ex_flush),
        .o_stall         (w_stall),
        .o_bubble        (w_bubble)
    );

    // Assemble the ID/EX record for the instruction currently in IF/ID.
    always_comb begin
        w_next             = ID_EX_BUBBLE;
        w_next.valid       = bus.if_valid;
        w_next.pc          = XLEN'(bus.if_pc);
        w_next.rd1         = XLEN'(w_rd1);
        w_next.rd2         = XLEN'(w_rd2);
        w_next.imm         = sign_extend(w_instr, w_ctrl.imm_src);
        w_next.rs1         = w_instr[19:15];
        w_next.rs2         = w_instr[24:20];
        w_next.rd          = w_instr[11:7];
        w_next.result_src  = w_ctrl.result_src;
        w_next.mem_write   = w_ctrl.mem_write;
        w_next.alu_src     = w_ctrl.alu_src;
        w_next.reg_write   = w_ctrl.reg_write;
        w_next.branch      = w_ctrl.branch;
        w_next.jump        = w_ctrl.jump;
        w_next.alu_control = w_ctrl.alu_control;
        w_next.funct3      = w_instr[14:12];
    end

    // Register file; write-back is never blocked by flush since it belongs to an older instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf <= '{default: '0};
        end else if (w_wb_en) begin
            r_rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    // ID/EX pipeline register: bubble on flush, load-use or empty IF/ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idex <= ID_EX_BUBBLE;
        end else if (w_bubble) begin
            r_idex <= ID_EX_BUBBLE;
        end else begin
            r_idex <= w_next;
        end
    end

    assign bus.stall          = w_stall;
    assign bus.ex_valid       = r_idex.valid;
    assign bus.ex_pc          = DATA_WIDTH'(r_idex.pc);
    assign bus.ex_rd1         = DATA_WIDTH'(r_idex.rd1);
    assign bus.ex_rd2         = DATA_WIDTH'(r_idex.rd2);
    assign bus.ex_imm         = DATA_WIDTH'(r_idex.imm);
    assign bus.ex_rs1         = ADDR_WIDTH'(r_idex.rs1);
    assign bus.ex_rs2         = ADDR_WIDTH'(r_idex.rs2);
    assign bus.ex_rd          = w_ex_rd;
    assign bus.ex_result_src  = r_idex.result_src;
    assign bus.ex_mem_write   = r_idex.mem_write;
    assign bus.ex_alu_src     = r_idex.alu_src;
    assign bus.ex_reg_write   = r_idex.reg_write;
    assign bus.ex_branch      = r_idex.branch;
    assign bus.ex_jump        = r_idex.jump;
    assign bus.ex_alu_control = r_idex.alu_control;
    assign bus.ex_funct3      = r_idex.funct3;
endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: each driven cycle pushes the expected ID/EX
// contents, which are popped and compared one clock later.
module tb_decode_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
    decode_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus4 ();
    logic [31:0] a0;
    logic [31:0] a0_4;

    decode_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .bus(bus), .a0(a0)
    );
    decode_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .a0(a0_4)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic        imm_care;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [1:0]  res;
        logic        alu_src;
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic [3:0]  aluc;
    } exp_t;

    exp_t q[$];
    int   n_tot = 0;
    int   n_bad = 0;
    logic [31:0] pc_ctr = 32'h100;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t bub();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic exp_t ins(input logic [31:0] rd1, input logic [31:0] rd2,
                                 input logic [31:0] imm, input logic imm_care,
                                 input logic [4:0] rs1, input logic [4:0] rd,
                                 input logic [1:0] res, input logic alu_src,
                                 input logic reg_write, input logic mem_write,
                                 input logic branch, input logic jump,
                                 input logic [3:0] aluc);
        exp_t e;
        e = '{default: '0};
        e.valid = 1'b1; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.imm_care = imm_care;
        e.rs1 = rs1; e.rd = rd; e.res = res; e.alu_src = alu_src;
        e.reg_write = reg_write; e.mem_write = mem_write; e.branch = branch;
        e.jump = jump; e.aluc = aluc;
        return e;
    endfunction

    task automatic cmp_ex(input exp_t e);
        chk("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
        chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(e.reg_write));
        chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(e.mem_write));
        chk("ex_branch", 32'(bus.ex_branch), 32'(e.branch));
        chk("ex_jump", 32'(bus.ex_jump), 32'(e.jump));
        if (e.valid) begin
            chk("ex_pc", bus.ex_pc, e.pc);
            chk("ex_rd1", bus.ex_rd1, e.rd1);
            chk("ex_rd2", bus.ex_rd2, e.rd2);
            chk("ex_rs1", 32'(bus.ex_rs1), 32'(e.rs1));
            chk("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
            chk("ex_result_src", 32'(bus.ex_result_src), 32'(e.res));
            chk("ex_alu_src", 32'(bus.ex_alu_src), 32'(e.alu_src));
            chk("ex_alu_control", 32'(bus.ex_alu_control), 32'(e.aluc));
            if (e.imm_care) chk("ex_imm", bus.ex_imm, e.imm);
        end
    endtask

    // One decode cycle: drive IF/ID, write-back and flush, check stall, then
    // check what lands in ID/EX after the edge.
    task automatic step(input logic v, input logic [31:0] instr,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wdat,
                        input logic fl, input logic exp_stall, input exp_t e);
        exp_t got_e;
        bus.if_valid = v;
        bus.if_instr = instr;
        bus.if_pc    = pc_ctr;
        bus.wb_we    = we;
        bus.wb_rd    = wrd;
        bus.wb_data  = wdat;
        bus.ex_flush = fl;
        e.pc = pc_ctr;
        pc_ctr += 32'd4;
        #1;
        chk("stall", 32'(bus.stall), 32'(exp_stall));
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.wb_we    = 1'b0;
        bus.ex_flush = 1'b0;
        if (q.size() == 0) begin
            chk("sb_empty", 32'(q.size()), 32'd1);
        end else begin
            got_e = q.pop_front();
            cmp_ex(got_e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0;
        bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.ex_flush = 1'b0;
        bus4.if_valid = 1'b0; bus4.if_instr = '0; bus4.if_pc = '0;
        bus4.wb_we = 1'b0; bus4.wb_rd = '0; bus4.wb_data = '0; bus4.ex_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_ex_pc", bus.ex_pc, 32'd0);
        chk("rst_ex_rd1", bus.ex_rd1, 32'd0);
        chk("rst_ex_imm", bus.ex_imm, 32'd0);
        chk("rst_ex_rd", 32'(bus.ex_rd), 32'd0);
        chk("rst_ex_reg_write", 32'(bus.ex_reg_write), 32'd0);
        chk("rst_ex_result_src", 32'(bus.ex_result_src), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_a0", a0, 32'd0);
        rst = 1'b0;

        // addi x6,x5,0 : x5 reads 0 after reset
        step(1, 32'h00028313, 0, 5'd0, 32'h0, 0, 0, ins(0, 0, 0, 1, 5, 6, 2'b00, 1, 1, 0, 0, 0, 4'h0));
        // x1 = 7, IF/ID empty
        step(0, 32'h00508513, 1, 5'd1, 32'd7, 0, 0, bub());
        // addi x10,x1,5
        step(1, 32'h00508513, 0, 5'd0, 32'h0, 0, 0, ins(7, 0, 5, 1, 1, 10, 2'b00, 1, 1, 0, 0, 0, 4'h0));
        chk("a0_before_wb", a0, 32'd0);
        step(0, 32'h0, 1, 5'd10, 32'd12, 0, 0, bub());
        chk("a0_after_wb", a0, 32'd12);
        // add x4,x3,x0 with same-cycle write-back of x3
        step(1, 32'h00018233, 1, 5'd3, 32'hDEAD, 0, 0, ins(32'hDEAD, 0, 0, 0, 3, 4, 2'b00, 0, 1, 0, 0, 0, 4'h0));
        // addi x7,x3,0 : array now holds the value
        step(1, 32'h00018393, 0, 5'd0, 32'h0, 0, 0, ins(32'hDEAD, 0, 0, 1, 3, 7, 2'b00, 1, 1, 0, 0, 0, 4'h0));
        // addi x8,x0,0 while writing x0: neither bypass nor write happens
        step(1, 32'h00000413, 1, 5'd0, 32'h55, 0, 0, ins(0, 0, 0, 1, 0, 8, 2'b00, 1, 1, 0, 0, 0, 4'h0));
        step(1, 32'h00000413, 0, 5'd0, 32'h0, 0, 0, ins(0, 0, 0, 1, 0, 8, 2'b00, 1, 1, 0, 0, 0, 4'h0));
        // beq x1,x3,+8
        step(1, 32'h00308463, 0, 5'd0, 32'h0, 0, 0, ins(7, 32'hDEAD, 8, 1, 1, 8, 2'b00, 0, 0, 0, 1, 0, 4'h1));
        // sw x3,4(x1)
        step(1, 32'h0030A223, 0, 5'd0, 32'h0, 0, 0, ins(7, 32'hDEAD, 4, 1, 1, 4, 2'b00, 1, 0, 1, 0, 0, 4'h0));
        // jal x1,+16
        step(1, 32'h010000EF, 0, 5'd0, 32'h0, 0, 0, ins(0, 0, 16, 1, 0, 1, 2'b10, 0, 1, 0, 0, 1, 4'h0));
        // lw x5,0(x2) then add x6,x5,x1 : one stall cycle, bubble, then add
        step(1, 32'h00012283, 0, 5'd0, 32'h0, 0, 0, ins(0, 0, 0, 1, 2, 5, 2'b01, 1, 1, 0, 0, 0, 4'h0));
        step(1, 32'h00128333, 0, 5'd0, 32'h0, 0, 1, bub());
        step(1, 32'h00128333, 0, 5'd0, 32'h0, 0, 0, ins(0, 7, 0, 0, 5, 6, 2'b00, 0, 1, 0, 0, 0, 4'h0));
        // Same pair with flush in the hazard cycle, plus a write-back of x9
        step(1, 32'h00012283, 0, 5'd0, 32'h0, 0, 0, ins(0, 0, 0, 1, 2, 5, 2'b01, 1, 1, 0, 0, 0, 4'h0));
        step(1, 32'h00128333, 1, 5'd9, 32'h99, 1, 0, bub());
        step(1, 32'h00128333, 0, 5'd0, 32'h0, 0, 0, ins(0, 7, 0, 0, 5, 6, 2'b00, 0, 1, 0, 0, 0, 4'h0));
        // addi x11,x9,0 : write during flush landed
        step(1, 32'h00048593, 0, 5'd0, 32'h0, 0, 0, ins(32'h99, 0, 0, 1, 9, 11, 2'b00, 1, 1, 0, 0, 0, 4'h0));
        // Plain flush of a valid instruction
        step(1, 32'h00048593, 0, 5'd0, 32'h0, 1, 0, bub());

        // Reset mid-stream clears ID/EX and the register file
        rst = 1'b1;
        bus.if_valid = 1'b1; bus.if_instr = 32'h00048593;
        @(posedge clk);
        #1;
        chk("mid_rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("mid_rst_a0", a0, 32'd0);
        rst = 1'b0;
        // addi x6,x1,0 : x1 cleared
        step(1, 32'h00008313, 0, 5'd0, 32'h0, 0, 0, ins(0, 0, 0, 1, 1, 6, 2'b00, 1, 1, 0, 0, 0, 4'h0));

        // ADDR_WIDTH = 4 instance: register 15 holds data, register 0 stays 0
        bus4.wb_we = 1'b1; bus4.wb_rd = 4'd15; bus4.wb_data = 32'hBEEF;
        @(posedge clk);
        #1;
        bus4.wb_we = 1'b0;
        bus4.if_valid = 1'b1; bus4.if_instr = 32'h00078093;
        @(posedge clk);
        #1;
        chk("w4_ex_valid", 32'(bus4.ex_valid), 32'd1);
        chk("w4_ex_rs1", 32'(bus4.ex_rs1), 32'd15);
        chk("w4_ex_rd1", bus4.ex_rd1, 32'hBEEF);
        bus4.wb_we = 1'b1; bus4.wb_rd = 4'd0; bus4.wb_data = 32'h77;
        bus4.if_instr = 32'h00000093;
        @(posedge clk);
        #1;
        chk("w4_x0_bypass", bus4.ex_rd1, 32'd0);
        bus4.wb_we = 1'b0;
        @(posedge clk);
        #1;
        chk("w4_x0_array", bus4.ex_rd1, 32'd0);
        bus4.if_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_pipe.md
# decode_pipe

Pipelined successor to the single-cycle decode datapath: decodes one RV32I instruction per cycle, reads a parametrised register file with write-back bypass, and registers all operands and control into an ID/EX pipeline register.
- Detects load-use hazards and stalls fetch for one cycle.
- Accepts a flush from EX on a taken branch or jump.
- Sits between the IF/ID register and the execute stage; write-back feeds it directly.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath and register width
- ADDR_WIDTH, 5, register index width; register file holds 2^ADDR_WIDTH entries

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  IF/ID holds a real instruction
- if_instr  in  DATA_WIDTH  instruction word
- if_pc  in  DATA_WIDTH  PC of if_instr
- wb_we  in  1  write-back enable
- wb_rd  in  ADDR_WIDTH  write-back destination
- wb_data  in  DATA_WIDTH  write-back value
- ex_flush  in  1  taken branch/jump resolved in EX; squash decode
- stall  out  1  combinational; fetch and IF/ID hold when high
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  DATA_WIDTH  registered PC, operands, extended immediate
- ex_rs1, ex_rs2, ex_rd  out  ADDR_WIDTH  registered register indices, for the EX forwarding unit
- ex_result_src  out  2  00 ALU, 01 memory, 10 PC+4
- ex_mem_write, ex_alu_src, ex_reg_write, ex_branch, ex_jump  out  1  registered control
- ex_alu_control  out  4  registered ALU opcode
- ex_funct3  out  3  branch condition select for EX
- a0  out  DATA_WIDTH  register x10, combinational from the register-file array

## Operation
- **Decode.** Decode if_instr with the existing control and sign-extension logic. The branch decision moves to EX, so no zero or negative flags enter this block.
- **Register file.**
  - Synchronous write when wb_we && wb_rd != 0.
  - Register 0 reads 0 always.
  - rst clears all entries to 0.
- **Bypass.** If wb_we && wb_rd != 0 && wb_rd == rs, the read port returns wb_data in the same cycle (write-through).
- **Load-use hazard.** Condition: ex_valid && ex_result_src == 01 && ex_rd != 0 && if_valid && (ex_rd == rs1 || ex_rd == rs2). On hazard:
  - stall = 1.
  - ID/EX loads a bubble: ex_valid = 0, ex_reg_write = 0, ex_mem_write = 0, ex_branch = 0, ex_jump = 0.
- **rs2 comparison gating.** Instructions with no rs2 field (I/U/J-type) still compare rs2. This conservative stall is accepted.
- **Flush.**
  - ex_flush forces a bubble into ID/EX.
  - stall = 0 while ex_flush is high, so fetch can redirect.
  - Flush has priority over the hazard.
- **Invalid input.** if_valid = 0 loads a bubble.
- **Bubble contents.** Data fields of a bubble are don't-care; the bench checks only that ex_valid and the four enables are 0.
- **Normal case.** With no stall and no flush, all ex_* fields are loaded from the current decode and ex_valid = if_valid.

## Timing
- Latency is 1 cycle: instruction at edge N appears on ex_* after edge N+1.
- stall is combinational from the ID/EX contents and if_instr. It is high for exactly one cycle per load-use pair; the next cycle the load has left EX and the check clears.
- **Reset.** Every ex_* output is 0, ex_valid = 0, stall = 0 (ID/EX is empty), a0 = 0. Reset mid-stream discards the ID/EX contents and the whole register file.
- **Write-back and read of the same register in one cycle.** The bypass returns the new value; the register is updated at the same edge.
- **Simultaneous flush and hazard.** Bubble; stall = 0.
- **Simultaneous flush and write-back.** The register-file write still occurs, since write-back belongs to an older instruction.

## Structure
- **Shared package (riscv_pkg):**
  - opcode constants
  - result_src encoding (RES_ALU, RES_MEM, RES_PC4)
  - ALU control encoding
  - a packed struct id_ex_t carrying every ex_* field, so the bubble is a single assignment of a constant ID_EX_BUBBLE.
- **Sub-module hazard_unit:** combinational load-use detection and flush priority, producing stall and the bubble select.
- **Reused:** the existing control and sign-extension modules.
- **Register file:** generalised to ADDR_WIDTH with bypass, instantiated inside this block.

## Test plan
- **Reset.** Assert rst for 2 cycles → all ex_* = 0, stall = 0, a0 = 0. Then read x5 → 0.
- **Decode.** Set x1 = 7, then present addi x10,x1,5 (0x00508513) → next cycle ex_rd1 = 7, ex_imm = 5, ex_rd = 10, ex_alu_src = 1, ex_reg_write = 1, ex_valid = 1. After write-back of 12 to x10, a0 = 12.
- **Bypass.** wb_we = 1, wb_rd = 3, wb_data = 0xDEAD in the same cycle as add x4,x3,x0 is decoded → ex_rd1 = 0xDEAD. A write to x0 → x0 reads 0.
- **Load-use.** Present lw x5,0(x2), then add x6,x5,x1 →
  - stall = 1 for one cycle.
  - A bubble (ex_valid = 0) follows the lw.
  - add enters ID/EX the cycle after the bubble with ex_rs1 = 5.
- **Flush with simultaneous hazard.** Same as the load-use case but with ex_flush = 1 in the hazard cycle → stall = 0, ex_valid = 0, ex_reg_write = 0.
- **Width parameter.** With ADDR_WIDTH = 4, a write to register 15 reads back, and register 0 stays 0.
